fft32_stage_sequencer: RTL and testbench

//  Sequencer for an iterative 32-point radix-2 FFT. A single shared butterfly-stage

---
 rtl/fft32_stage_sequencer.sv | 113 +++++++++++
 tb/tb_fft32_stage_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft32_stage_sequencer.sv
// Pass sequencer for an iterative radix-2 FFT: accepts a frame, steps the shared
// butterfly datapath through P_STAGES passes, then holds the result until taken.
module fft32_stage_sequencer #(
    parameter int unsigned P_STAGES   = 5,
    parameter int unsigned P_DP_LAT   = 1,
    parameter int unsigned P_CNT_BITS = 8,
    localparam int unsigned SW = (P_STAGES > 1) ? $clog2(P_STAGES) : 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_flush,
    output logic                  o_load,
    output logic                  o_step,
    output logic [SW-1:0]         o_stage,
    output logic                  o_busy,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [P_CNT_BITS-1:0] o_frame_cnt
);

    localparam int unsigned LW = (P_DP_LAT > 1) ? $clog2(P_DP_LAT) : 1;
    localparam logic [LW-1:0] LAT_LAST   = LW'(P_DP_LAT - 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(P_STAGES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [SW-1:0]         stage_q, stage_d;
    logic [LW-1:0]         lat_q, lat_d;
    logic [P_CNT_BITS-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        lat_d   = lat_q;
        cnt_d   = cnt_q;
        o_ready = 1'b0;
        o_load  = 1'b0;
        o_step  = 1'b0;
        o_busy  = 1'b0;
        o_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Outputs stay quiet while reset is held, even though state reads IDLE.
                o_ready = ~i_flush & RST;
                o_load  = i_valid & o_ready;
                if (o_load) begin
                    state_d = ST_RUN;
                    stage_d = '0;
                    lat_d   = '0;
                end
            end
            ST_RUN: begin
                o_busy = RST;
                if (lat_q == LAT_LAST) begin
                    o_step = ~i_flush & RST;
                    lat_d  = '0;
                    if (stage_q == STAGE_LAST) begin
                        state_d = ST_HOLD;
                    end else begin
                        stage_d = stage_q + SW'(1);
                    end
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            ST_HOLD: begin
                o_busy  = RST;
                o_valid = ~i_flush & RST;
                if (o_valid && i_ready) begin
                    state_d = ST_IDLE;
                    stage_d = '0;
                    cnt_d   = cnt_q + P_CNT_BITS'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                stage_d = '0;
                lat_d   = '0;
            end
        endcase

        // Flush overrides every state; the counter is left alone.
        if (i_flush) begin
            state_d = ST_IDLE;
            stage_d = '0;
            lat_d   = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            lat_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            lat_q   <= lat_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_stage     = stage_q;
    assign o_frame_cnt = cnt_q;

endmodule

// File: tb/tb_fft32_stage_sequencer.sv
// Directed bench for fft32_stage_sequencer: per-cycle expected handshake/stage vectors
// are queued as stimulus is driven and compared at the falling edge.
module tb_fft32_stage_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [1:0] vin = '0;
    logic [1:0] rin = '0;
    logic [1:0] fin = '0;
    logic [1:0] rdy, load, step, busy, vld;
    logic [2:0] stg  [2];
    logic [7:0] fcnt [2];

    int errors = 0;
    int checks = 0;
    int tag    = 0;
    logic [7:0] fc [2];

    typedef struct {
        int         tag;
        logic [7:0] exp;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    always #5 CLK = ~CLK;

    fft32_stage_sequencer #(.P_STAGES(5), .P_DP_LAT(1), .P_CNT_BITS(8)) dut5 (
        .CLK(CLK), .RST(RST), .i_valid(vin[0]), .o_ready(rdy[0]), .i_flush(fin[0]),
        .o_load(load[0]), .o_step(step[0]), .o_stage(stg[0]), .o_busy(busy[0]),
        .o_valid(vld[0]), .i_ready(rin[0]), .o_frame_cnt(fcnt[0])
    );

    fft32_stage_sequencer #(.P_STAGES(5), .P_DP_LAT(3), .P_CNT_BITS(8)) dut3 (
        .CLK(CLK), .RST(RST), .i_valid(vin[1]), .o_ready(rdy[1]), .i_flush(fin[1]),
        .o_load(load[1]), .o_step(step[1]), .o_stage(stg[1]), .o_busy(busy[1]),
        .o_valid(vld[1]), .i_ready(rin[1]), .o_frame_cnt(fcnt[1])
    );

    function automatic logic [7:0] obs(input int sel);
        return {rdy[sel], load[sel], step[sel], busy[sel], vld[sel], stg[sel]};
    endfunction

    // Scoreboard: one queued vector per cycle, popped at the falling edge of that cycle.
    always @(negedge CLK) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            checks++;
            assert (obs(0) === e.exp) else begin
                errors++;
                $error("FAIL lat1_cycle%0d rdy/ld/st/bsy/vld/stg got=%b want=%b",
                       e.tag, obs(0), e.exp);
            end
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            checks++;
            assert (obs(1) === e.exp) else begin
                errors++;
                $error("FAIL lat3_cycle%0d rdy/ld/st/bsy/vld/stg got=%b want=%b",
                       e.tag, obs(1), e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input int sel, input logic r, input logic l, input logic s,
                        input logic b, input logic v, input int stage);
        exp_t e;
        e.tag = tag++;
        e.exp = {r, l, s, b, v, 3'(stage)};
        if (sel == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic check_cnt(input int sel, input string name);
        checks++;
        assert (fcnt[sel] === fc[sel]) else begin
            errors++;
            $error("FAIL %s frame_cnt got=%0d want=%0d", name, fcnt[sel], fc[sel]);
        end
    endtask

    // Full frame: accept, P_STAGES*lat run cycles, 'hold' backpressure cycles, handoff.
    task automatic frame(input int sel, input int lat, input int hold);
        vin[sel] = 1'b1;
        rin[sel] = 1'b0;
        push(sel, 1, 1, 0, 0, 0, 0);
        tick();
        vin[sel] = 1'b0;
        for (int s = 0; s < 5; s++) begin
            for (int l = 0; l < lat; l++) begin
                push(sel, 0, 0, (l == lat - 1), 1, 0, s);
                tick();
            end
        end
        for (int h = 0; h < hold; h++) begin
            push(sel, 0, 0, 0, 1, 1, 4);
            tick();
        end
        rin[sel] = 1'b1;
        push(sel, 0, 0, 0, 1, 1, 4);
        tick();
        rin[sel] = 1'b0;
        fc[sel] = fc[sel] + 8'd1;
        check_cnt(sel, "frame_done");
    endtask

    initial begin
        fc[0] = '0;
        fc[1] = '0;

        // Reset state while RST is held low.
        #1;
        checks++;
        assert ({obs(0), obs(1)} === 16'h0000) else begin
            errors++;
            $error("FAIL reset_outputs got=%h want=0000", {obs(0), obs(1)});
        end
        check_cnt(0, "reset_cnt");
        tick();
        RST = 1'b1;
        tick();
        push(0, 1, 0, 0, 0, 0, 0);
        push(1, 1, 0, 0, 0, 0, 0);
        tick();

        // Single frame, latency 1, immediate acceptance; then idle next cycle.
        frame(0, 1, 0);
        push(0, 1, 0, 0, 0, 0, 0);
        tick();

        // Backpressure for 10 cycles.
        frame(0, 1, 10);
        push(0, 1, 0, 0, 0, 0, 0);
        tick();

        // Latency 3: each stage held 3 cycles, valid at cycle 16.
        frame(1, 3, 0);
        push(1, 1, 0, 0, 0, 0, 0);
        tick();

        // Flush at stage 2 of RUN.
        vin[0] = 1'b1;
        push(0, 1, 1, 0, 0, 0, 0);
        tick();
        vin[0] = 1'b0;
        push(0, 0, 0, 1, 1, 0, 0);
        tick();
        push(0, 0, 0, 1, 1, 0, 1);
        tick();
        fin[0] = 1'b1;
        push(0, 0, 0, 0, 1, 0, 2);
        tick();
        fin[0] = 1'b0;
        push(0, 1, 0, 0, 0, 0, 0);
        tick();
        // Flush together with i_valid in IDLE: no accept.
        fin[0] = 1'b1;
        vin[0] = 1'b1;
        push(0, 0, 0, 0, 0, 0, 0);
        tick();
        fin[0] = 1'b0;
        vin[0] = 1'b0;
        push(0, 1, 0, 0, 0, 0, 0);
        tick();
        check_cnt(0, "flush_run_cnt");

        // Flush together with i_ready in HOLD: frame dropped, not counted.
        vin[0] = 1'b1;
        push(0, 1, 1, 0, 0, 0, 0);
        tick();
        vin[0] = 1'b0;
        for (int s = 0; s < 5; s++) begin
            push(0, 0, 0, 1, 1, 0, s);
            tick();
        end
        fin[0] = 1'b1;
        rin[0] = 1'b1;
        push(0, 0, 0, 0, 1, 0, 4);
        tick();
        fin[0] = 1'b0;
        rin[0] = 1'b0;
        push(0, 1, 0, 0, 0, 0, 0);
        tick();
        check_cnt(0, "flush_hold_cnt");

        // Reset asserted mid-RUN.
        vin[0] = 1'b1;
        push(0, 1, 1, 0, 0, 0, 0);
        tick();
        vin[0] = 1'b0;
        push(0, 0, 0, 1, 1, 0, 0);
        tick();
        RST = 1'b0;
        #1;
        checks++;
        assert (obs(0) === 8'h00) else begin
            errors++;
            $error("FAIL reset_midrun got=%b want=00000000", obs(0));
        end
        fc[0] = '0;
        fc[1] = '0;
        check_cnt(0, "reset_midrun_cnt");
        tick();
        RST = 1'b1;
        #1;
        checks++;
        assert (rdy[0] === 1'b1) else begin
            errors++;
            $error("FAIL reset_release_ready got=%b want=1", rdy[0]);
        end
        check_cnt(0, "reset_release_cnt");
        tick();

        // 256 back-to-back frames, 7 cycles apart: counter wraps 255 -> 0.
        for (int n = 0; n < 256; n++) begin
            frame(0, 1, 0);
        end
        checks++;
        assert (fcnt[0] === 8'd0) else begin
            errors++;
            $error("FAIL wrap_cnt got=%0d want=0", fcnt[0]);
        end

        tick();
        checks++;
        assert (q0.size() + q1.size() === 0) else begin
            errors++;
            $error("FAIL queue_drain got=%0d want=0", q0.size() + q1.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
